ram_responder: RTL and testbench
================================

// Module: ram_responder
// PURPOSE
//  Memory-side responder for the core's RAM port: answers fetches/loads on the read channel and merges
//  bit-masked stores on the write channel into a local word array. Sits outside the core in the difftest
//  top, driving RamReadData. Owns a post-reset clear sequence and reports readiness and address errors.
// PARAMETERS
//  DEPTH       256                number of 64-bit words; power of two, 16..4096
//  READ_LAT    1                  read latency in cycles, 1..4 (1 matches core fetch timing)
//  BASE_ADDR   64'h0000_0000_8000_0000  byte address of word 0; must be 8-byte aligned
//  INIT_VALUE  64'h0                value written to every word during the clear sweep
// PORTS
//  clk             in   1    single clock; all state on rising edge
//  rst             in   1    reset, asynchronous assert, active-low (0 = reset)
//  RamReadEnable   in   1    read request this cycle
//  RamReadAddr     in   64   read byte address
//  RamReadData     out  64   read data, valid READ_LAT cycles after request
//  RamWriteEnable  in   1    write request this cycle
//  RamWriteAddr    in   64   write byte address
//  RamWriteMask    in   64   per-bit write mask, 1 = update bit
//  RamWriteData    in   64   write data
//  ram_ready       out  1    1 once clear sweep finished
//  rd_valid        out  1    qualifies RamReadData
//  addr_err        out  1    sticky: an out-of-range access was seen since reset
// BEHAVIOUR
//  Reset (rst=0, async): RamReadData=0, rd_valid=0, ram_ready=0, addr_err=0, read pipe flushed, FSM=CLEAR,
//   sweep index=0. Array contents are not reset directly; the sweep rewrites them.
//  Word index = (addr - BASE_ADDR) >> 3; addr[2:0] ignored. In range iff BASE_ADDR <= addr < BASE_ADDR+8*DEPTH
//   (compare in 64 bits, no wrap).
//  FSM CLEAR: each cycle mem[idx] <= INIT_VALUE, idx++; at idx==DEPTH-1 go to READY next cycle (exactly DEPTH
//   cycles after reset release). READY: ram_ready=1, stays until reset. No other states.
//  During CLEAR: core writes dropped; reads accepted into pipe but return 0 with rd_valid=1.
//  Write (READY, in range): mem[w] <= (mem[w] & ~RamWriteMask) | (RamWriteData & RamWriteMask). Mask 0 = no-op.
//  Read: request at cycle t -> RamReadData/rd_valid at cycle t+READ_LAT (registered output, shift pipe of
//   READ_LAT stages). Fully pipelined, one request per cycle, no stall, no backpressure.
//  Read and write same word same cycle: read-first -- read returns pre-write value.
//  Out-of-range read: returns 64'h0, rd_valid=1, sets addr_err. Out-of-range write: dropped, sets addr_err.
//  addr_err cleared only by reset. RamReadEnable=0 -> rd_valid=0 in that slot, RamReadData holds last value.
//  Reset mid-operation: pending pipe entries discarded, sweep restarts from 0.
// STRUCTURE
//  defines.v: DATA_BUS, ADDR_BUS (existing); add RAM_ST_CLEAR/RAM_ST_READY state encodings.
//  Sub-module ram_rd_pipe (width 65 = valid+data, depth READ_LAT), built from the existing DFF cell.
//  Array: reg [63:0] mem[0:DEPTH-1]; single write port shared by sweep and core store via FSM mux.
// TESTING
//  1 reset, hold rst=0 5 cycles, release -> ram_ready rises exactly DEPTH cycles later; read 0x80000000
//    then returns INIT_VALUE with rd_valid=1 one cycle later (READ_LAT=1).
//  2 write 0x80000008 data=64'hDEAD_BEEF_0123_4567 mask=all-1s, then mask=64'h0000_0000_FFFF_FFFF
//    data=64'h0 -> read 0x8000000C returns 64'hDEAD_BEEF_0000_0000.
//  3 same cycle: write 64'h1111 to 0x80000010 and read 0x80000010 -> read returns old value; next read 64'h1111.
//  4 back-to-back reads 0x80000000,08,10,18 every cycle with READ_LAT=3 -> four consecutive rd_valid
//    beats, in order, starting 3 cycles after first request.
//  5 read 0x7FFFFFF8 and write 0x80000000+8*DEPTH -> read gives 0 with rd_valid, write has no effect,
//    addr_err=1 and stays 1; next reset clears it.
//  6 assert rst=0 with reads in flight and sweep running -> rd_valid=0 immediately, after release sweep
//    restarts and prior written data reads back INIT_VALUE.

Source files
------------

// File: rtl/ram_responder_pkg.sv
// ram_responder_pkg: shared widths, FSM state encodings and read-beat type for the RAM responder
package ram_responder_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  typedef enum logic {RAM_ST_CLEAR = 1'b0, RAM_ST_READY = 1'b1} ram_st_e;
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } rd_beat_t;
endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: LAT-stage read return pipe; data only advances with a valid beat so the output holds
module ram_rd_pipe
  import ram_responder_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  rd_beat_t beat_i,
  output rd_beat_t beat_o
);
  rd_beat_t [LAT-1:0] stage_q;
  rd_beat_t [LAT:0]   chain;
  assign chain  = {stage_q, beat_i};
  assign beat_o = stage_q[LAT-1];
  always_ff @(posedge clk or negedge rst)
    if (!rst) stage_q <= '0;
    else
      for (int i = 0; i < LAT; i++) begin
        stage_q[i].valid <= chain[i].valid;
        if (chain[i].valid) stage_q[i].data <= chain[i].data;
      end
endmodule

// File: rtl/ram_responder.sv
// ram_responder: memory-side RAM port responder with post-reset clear sweep, masked stores,
// pipelined reads and a sticky out-of-range flag
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned       DEPTH      = 256,
  parameter int unsigned       READ_LAT   = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter logic [DATA_W-1:0] INIT_VALUE = 64'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RamReadEnable,
  input  logic [ADDR_W-1:0] RamReadAddr,
  output logic [DATA_W-1:0] RamReadData,
  input  logic              RamWriteEnable,
  input  logic [ADDR_W-1:0] RamWriteAddr,
  input  logic [DATA_W-1:0] RamWriteMask,
  input  logic [DATA_W-1:0] RamWriteData,
  output logic              ram_ready,
  output logic              rd_valid,
  output logic              addr_err
);
  localparam int unsigned       IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] END_ADDR = BASE_ADDR + 64'(DEPTH) * 64'd8;
  logic [DATA_W-1:0] mem [DEPTH];
  ram_st_e           state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, rd_idx, wr_idx, mem_idx;
  logic              err_q, err_d, rd_in, wr_in, clear, mem_we;
  logic [DATA_W-1:0] mem_wd;
  rd_beat_t          beat_in, beat_out;
  assign rd_in  = RamReadAddr >= BASE_ADDR && RamReadAddr < END_ADDR;
  assign wr_in  = RamWriteAddr >= BASE_ADDR && RamWriteAddr < END_ADDR;
  assign rd_idx = IDX_W'((RamReadAddr - BASE_ADDR) >> 3);
  assign wr_idx = IDX_W'((RamWriteAddr - BASE_ADDR) >> 3);
  assign clear  = state_q == RAM_ST_CLEAR;
  // One write port: the sweep owns it while clearing, core stores are dropped until ready
  assign mem_we  = clear || (RamWriteEnable && wr_in);
  assign mem_idx = clear ? idx_q : wr_idx;
  assign mem_wd  = clear ? INIT_VALUE : (mem[wr_idx] & ~RamWriteMask) | (RamWriteData & RamWriteMask);
  always_comb begin
    state_d = (clear && idx_q == IDX_W'(DEPTH - 1)) ? RAM_ST_READY : state_q;
    idx_d   = clear ? idx_q + 1'b1 : idx_q;
    err_d   = err_q | (RamReadEnable && !rd_in) | (RamWriteEnable && !wr_in);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= RAM_ST_CLEAR;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  always_ff @(posedge clk)
    if (mem_we) mem[mem_idx] <= mem_wd;
  // Array read is combinational, so a same-cycle store is seen only by later reads
  assign beat_in.valid = RamReadEnable;
  assign beat_in.data  = (!clear && rd_in) ? mem[rd_idx] : '0;
  ram_rd_pipe #(.LAT(READ_LAT)) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .beat_i (beat_in),
    .beat_o (beat_out)
  );
  assign RamReadData = beat_out.data;
  assign rd_valid    = beat_out.valid;
  assign ram_ready   = state_q == RAM_ST_READY;
  assign addr_err    = err_q;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed checks of two responders (read latency 1 and 3) driven by shared stimulus
module tb_ram_responder;
  localparam int unsigned DEPTH = 16;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] INIT  = 64'hC0DE_0000_0000_00AA;
  localparam logic [63:0] ONES  = '1;
  logic        clk = 1'b0, rst = 1'b0;
  logic        ren = 1'b0, wen = 1'b0;
  logic [63:0] raddr = '0, waddr = '0, wmask = '0, wdata = '0;
  logic [63:0] a_data, b_data;
  logic        a_valid, a_ready, a_err, b_valid, b_ready, b_err;
  int          errors = 0, checks = 0;
  always #5 clk = ~clk;
  ram_responder #(.DEPTH(DEPTH), .READ_LAT(1), .BASE_ADDR(BASE), .INIT_VALUE(INIT)) dut_a (
    .clk(clk), .rst(rst), .RamReadEnable(ren), .RamReadAddr(raddr), .RamReadData(a_data),
    .RamWriteEnable(wen), .RamWriteAddr(waddr), .RamWriteMask(wmask), .RamWriteData(wdata),
    .ram_ready(a_ready), .rd_valid(a_valid), .addr_err(a_err)
  );
  ram_responder #(.DEPTH(DEPTH), .READ_LAT(3), .BASE_ADDR(BASE), .INIT_VALUE(INIT)) dut_b (
    .clk(clk), .rst(rst), .RamReadEnable(ren), .RamReadAddr(raddr), .RamReadData(b_data),
    .RamWriteEnable(wen), .RamWriteAddr(waddr), .RamWriteMask(wmask), .RamWriteData(wdata),
    .ram_ready(b_ready), .rd_valid(b_valid), .addr_err(b_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  initial begin
    repeat (5) tick();
    chk("rst_data", a_data, 64'h0);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    rst = 1'b1;
    ren = 1'b1; raddr = BASE;
    tick();
    chk("clr_rd_valid", a_valid, 1'b1);
    chk("clr_rd_data", a_data, 64'h0);
    ren = 1'b0;
    wen = 1'b1; waddr = BASE + 64'h8; wmask = ONES; wdata = ONES;
    repeat (DEPTH - 2) tick();
    wen = 1'b0;
    chk("ready_early", a_ready, 1'b0);
    tick();
    chk("ready_a", a_ready, 1'b1);
    chk("ready_b", b_ready, 1'b1);
    ren = 1'b1; raddr = BASE;
    tick();
    chk("t1_valid", a_valid, 1'b1);
    chk("t1_data", a_data, INIT);
    ren = 1'b0;
    chk("t1_hold", a_valid, 1'b1);
    tick();
    chk("idle_valid", a_valid, 1'b0);
    chk("idle_hold", a_data, INIT);
    wen = 1'b1; waddr = BASE + 64'h8; wmask = ONES; wdata = 64'hDEAD_BEEF_0123_4567;
    tick();
    waddr = BASE + 64'hC; wmask = 64'h0000_0000_FFFF_FFFF; wdata = 64'h0;
    tick();
    wmask = 64'h0; wdata = ONES;
    tick();
    wen = 1'b0; ren = 1'b1; raddr = BASE + 64'hC;
    tick();
    chk("t2_merge", a_data, 64'hDEAD_BEEF_0000_0000);
    wen = 1'b1; waddr = BASE + 64'h10; wmask = ONES; wdata = 64'h1111; raddr = BASE + 64'h10;
    tick();
    chk("t3_read_first", a_data, INIT);
    wen = 1'b0;
    tick();
    chk("t3_new", a_data, 64'h1111);
    ren = 1'b0;
    repeat (3) tick();
    chk("t4_quiet", b_valid, 1'b0);
    ren = 1'b1; raddr = BASE;
    tick();
    chk("t4_lat1", b_valid, 1'b0);
    raddr = BASE + 64'h8;
    tick();
    chk("t4_lat2", b_valid, 1'b0);
    raddr = BASE + 64'h10;
    tick();
    chk("t4_b0_valid", b_valid, 1'b1);
    chk("t4_b0_data", b_data, INIT);
    raddr = BASE + 64'h18;
    tick();
    chk("t4_b1_data", b_data, 64'hDEAD_BEEF_0000_0000);
    ren = 1'b0;
    tick();
    chk("t4_b2_data", b_data, 64'h1111);
    chk("t4_b2_valid", b_valid, 1'b1);
    tick();
    chk("t4_b3_data", b_data, INIT);
    chk("t4_b3_valid", b_valid, 1'b1);
    tick();
    chk("t4_end_valid", b_valid, 1'b0);
    chk("t4_end_hold", b_data, INIT);
    ren = 1'b1; raddr = BASE + 64'h78;
    tick();
    chk("t5_last_word", a_data, INIT);
    chk("t5_no_err", a_err, 1'b0);
    raddr = 64'h0000_0000_7FFF_FFF8;
    wen = 1'b1; waddr = BASE + 64'(DEPTH) * 64'd8; wmask = ONES; wdata = ONES;
    tick();
    chk("t5_oor_valid", a_valid, 1'b1);
    chk("t5_oor_data", a_data, 64'h0);
    chk("t5_err_a", a_err, 1'b1);
    chk("t5_err_b", b_err, 1'b1);
    wen = 1'b0; raddr = BASE;
    tick();
    chk("t5_wr_dropped", a_data, INIT);
    chk("t5_err_sticky", a_err, 1'b1);
    raddr = BASE + 64'h8;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("t6_valid_a", a_valid, 1'b0);
    chk("t6_valid_b", b_valid, 1'b0);
    chk("t6_err", a_err, 1'b0);
    chk("t6_ready", a_ready, 1'b0);
    chk("t6_data", a_data, 64'h0);
    tick();
    tick();
    rst = 1'b1; ren = 1'b0;
    repeat (5) tick();
    ren = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_sweep_valid_b", b_valid, 1'b0);
    tick();
    rst = 1'b1; ren = 1'b0;
    repeat (DEPTH - 1) tick();
    chk("t6_ready_early", a_ready, 1'b0);
    tick();
    chk("t6_ready", a_ready, 1'b1);
    ren = 1'b1; raddr = BASE + 64'h8;
    tick();
    chk("t6_cleared_8", a_data, INIT);
    raddr = BASE + 64'h10;
    tick();
    chk("t6_cleared_10", a_data, INIT);
    ren = 1'b0;
    tick();
    chk("t6_b_data", b_data, INIT);
    chk("t6_b_valid", b_valid, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
